// File: rtl/ysyx_23060061_icache_pkg.sv
// Shared types and helpers for the ysyx_23060061 instruction cache.
// Contents: the cache FSM state enum, AXI-Lite response codes, and
// address-split width helpers that take NSETS / LINE_WORDS as arguments.
package ysyx_23060061_icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_AR,
    REFILL_R,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of the word-select field inside a line.
  function automatic int unsigned word_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Width of the full byte offset inside a line.
  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned nsets);
    return $clog2(nsets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned nsets,
                                           input int unsigned line_words);
    return 32 - idx_bits(nsets) - off_bits(line_words);
  endfunction

endpackage

// File: rtl/ysyx_23060061_icache_array.sv
// Storage for the direct-mapped icache: valid bits, tags and line data.
// Ports:
//   clk, rst          clock, synchronous active-low reset (clears valid bits)
//   rd_index_i/rd_offset_i -> rd_valid_o, rd_tag_o, rd_data_o
//                     combinational read port
//   wr_index_i, wr_offset_i, data_we_i, wr_data_i   data word write
//   tag_we_i, wr_tag_i                              tag write
//   valid_set_i / valid_inv_i                       per-line valid set / clear
//   clr_all_i                                       clear every valid bit
module ysyx_23060061_icache_array
  import ysyx_23060061_icache_pkg::*;
#(
  parameter int unsigned NSETS      = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [idx_bits(NSETS)-1:0]              rd_index_i,
  input  logic [word_bits(LINE_WORDS)-1:0]        rd_offset_i,
  output logic                                    rd_valid_o,
  output logic [tag_bits(NSETS, LINE_WORDS)-1:0]  rd_tag_o,
  output logic [31:0]                             rd_data_o,
  input  logic [idx_bits(NSETS)-1:0]              wr_index_i,
  input  logic [word_bits(LINE_WORDS)-1:0]        wr_offset_i,
  input  logic                                    data_we_i,
  input  logic [31:0]                             wr_data_i,
  input  logic                                    tag_we_i,
  input  logic [tag_bits(NSETS, LINE_WORDS)-1:0]  wr_tag_i,
  input  logic                                    valid_set_i,
  input  logic                                    valid_inv_i,
  input  logic                                    clr_all_i
);

  localparam int unsigned TAG_W = tag_bits(NSETS, LINE_WORDS);

  logic [NSETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [31:0]      data_q [NSETS][LINE_WORDS];

  // Clear-all wins; set and invalidate never coincide on the same line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (valid_set_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end else if (valid_inv_i) begin
      valid_q[wr_index_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
    if (data_we_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/ysyx_23060061_icache.sv
// Direct-mapped read-only instruction cache between the IFU AXI-Lite read
// port (s_*) and the arbiter's IFU slave port (m_*). Hits answer in two
// cycles; misses refill the line as LINE_WORDS single-beat reads, beat 0 first.
// Ports:
//   clk, rst (sync, active-low), flush (invalidate-all pulse)
//   s_ar*/s_r*   IFU read address / data channels
//   m_ar*/m_r*   arbiter read address / data channels
//   hit_cnt, miss_cnt  performance counters
// Build option: define YSYX_23060061_ICACHE_PERF_EN to implement the
// counters; otherwise both outputs are tied to zero.
module ysyx_23060061_icache
  import ysyx_23060061_icache_pkg::*;
#(
  parameter int unsigned NSETS      = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned WORD_W = word_bits(LINE_WORDS);
  localparam int unsigned OFF_W  = off_bits(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_bits(NSETS);
  localparam int unsigned TAG_W  = tag_bits(NSETS, LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [31:2]       addr_q, addr_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              fpend_q, fpend_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_off;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              hit;
  logic              data_we, tag_we, valid_set, valid_inv, clr_all;
  logic              unused_araddr;

  assign unused_araddr = ^s_araddr[1:0];

  assign req_tag = addr_q[31 -: TAG_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];
  assign req_off = addr_q[2 +: WORD_W];
  assign hit     = rd_valid && (rd_tag == req_tag);

  ysyx_23060061_icache_array #(
    .NSETS      (NSETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_index_i  (req_idx),
    .rd_offset_i (req_off),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_index_i  (req_idx),
    .wr_offset_i (beat_q),
    .data_we_i   (data_we),
    .wr_data_i   (m_rdata),
    .tag_we_i    (tag_we),
    .wr_tag_i    (req_tag),
    .valid_set_i (valid_set),
    .valid_inv_i (valid_inv),
    .clr_all_i   (clr_all)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      fpend_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      fpend_q <= fpend_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    err_d     = err_q;
    fpend_d   = fpend_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    valid_set = 1'b0;
    valid_inv = 1'b0;
    clr_all   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_all = flush;
        if (s_arvalid) begin
          addr_d  = s_araddr[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        // Hit test reads the pre-flush valid bits; the clear lands at the edge.
        clr_all = flush;
        if (hit) begin
          rdata_d = rd_data;
          rresp_d = RESP_OKAY;
          state_d = RESP;
        end else begin
          beat_d  = '0;
          err_d   = 1'b0;
          rresp_d = RESP_OKAY;
          state_d = REFILL_AR;
        end
      end
      REFILL_AR: begin
        if (flush) fpend_d = 1'b1;
        if (m_arready) state_d = REFILL_R;
      end
      REFILL_R: begin
        if (flush) fpend_d = 1'b1;
        if (m_rvalid) begin
          data_we = 1'b1;
          // The old line is dead once its first word is overwritten.
          if (beat_q == '0) valid_inv = 1'b1;
          if (beat_q == req_off) rdata_d = m_rdata;
          if ((m_rresp != RESP_OKAY) && !err_q) begin
            err_d   = 1'b1;
            rresp_d = m_rresp;
          end
          if (beat_q != LAST_BEAT) begin
            beat_d  = beat_q + 1'b1;
            state_d = REFILL_AR;
          end else begin
            tag_we    = 1'b1;
            valid_set = !err_d && !fpend_q && !flush;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        clr_all = flush;
        if (s_rready) begin
          fpend_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are gated by rst so a mid-refill reset drops them at once.
  assign s_arready = rst && (state_q == IDLE);
  assign s_rvalid  = rst && (state_q == RESP);
  assign m_arvalid = rst && (state_q == REFILL_AR);
  assign m_rready  = rst && (state_q == REFILL_R);
  assign m_araddr  = m_arvalid ? {req_tag, req_idx, beat_q, 2'b00} : '0;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

`ifdef YSYX_23060061_ICACHE_PERF_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_q  <= hit_q + 32'd1;
      else     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060061_icache.sv
// Directed self-checking bench for ysyx_23060061_icache with a single-beat
// AXI-Lite memory model on the arbiter side.
module tb_ysyx_23060061_icache;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int total = 0;
  int bad   = 0;
  int exp_hits  = 0;
  int exp_miss  = 0;
  int overlap_cnt = 0;

  logic [31:0] arlog [$];
  logic [31:0] cur_addr = '0;
  logic [31:0] err_addr;

  ysyx_23060061_icache #(
    .NSETS      (16),
    .LINE_WORDS (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0011;
      32'h8000_0004: return 32'h0000_0022;
      32'h8000_0008: return 32'h0000_0033;
      32'h8000_000C: return 32'h0000_0044;
      default:       return a + 32'h1000_0000;
    endcase
  endfunction

  function automatic logic [31:0] perf(input int v);
`ifdef YSYX_23060061_ICACHE_PERF_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: accept every AR, answer with one R beat in the next cycle.
  always @(negedge clk) begin
    if (m_arvalid && m_rready) overlap_cnt++;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rresp   = 2'b00;
    m_rdata   = '0;
    if (rst && m_arvalid) begin
      m_arready = 1'b1;
      arlog.push_back(m_araddr);
      cur_addr = m_araddr;
    end else if (rst && m_rready) begin
      m_rvalid = 1'b1;
      m_rdata  = mem_rd(cur_addr);
      m_rresp  = (cur_addr == err_addr) ? 2'b10 : 2'b00;
    end
  end

  task automatic fetch(input string tag, input logic [31:0] a, input bit exp_hit,
                       input logic [31:0] exp_d, input logic [1:0] exp_r, input int hold);
    int n;
    int lat;
    int base;
    base = arlog.size();
    @(negedge clk);
    s_araddr  = a;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".arready"}, 32'(s_arready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    lat = 0;
    while (!s_rvalid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!s_rvalid) begin
      chk({tag, ".timeout"}, 32'(s_rvalid), 32'd1);
      return;
    end
    if (exp_hit) exp_hits++;
    else         exp_miss++;
    chk({tag, ".lat"}, 32'(lat), exp_hit ? 32'd1 : 32'(1 + 2 * LW));
    chk({tag, ".nbeats"}, 32'(arlog.size() - base), exp_hit ? 32'd0 : 32'(LW));
    if (!exp_hit) begin
      for (int i = 0; i < LW; i++) begin
        if (base + i < arlog.size())
          chk({tag, ".araddr"}, arlog[base + i], (a & 32'hFFFF_FFF0) + 32'(4 * i));
      end
    end
    chk({tag, ".rdata"}, s_rdata, exp_d);
    chk({tag, ".rresp"}, 32'(s_rresp), 32'(exp_r));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, ".hold_rvalid"}, 32'(s_rvalid), 32'd1);
      chk({tag, ".hold_rdata"}, s_rdata, exp_d);
    end
    s_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_rready = 1'b0;
    chk({tag, ".rvalid_drop"}, 32'(s_rvalid), 32'd0);
    chk({tag, ".next_arready"}, 32'(s_arready), 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    err_addr  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("rst.arready", 32'(s_arready), 32'd0);
    chk("rst.rvalid", 32'(s_rvalid), 32'd0);
    chk("rst.arvalid", 32'(m_arvalid), 32'd0);
    chk("rst.rready", 32'(m_rready), 32'd0);
    chk("rst.rdata", s_rdata, 32'd0);
    chk("rst.rresp", 32'(s_rresp), 32'd0);
    chk("rst.araddr", m_araddr, 32'd0);
    chk("rst.hit_cnt", hit_cnt, 32'd0);
    chk("rst.miss_cnt", miss_cnt, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst.arready", 32'(s_arready), 32'd1);

    fetch("cold", 32'h8000_0004, 1'b0, 32'h0000_0022, 2'b00, 0);
    chk("cold.miss_cnt", miss_cnt, perf(1));
    fetch("hit", 32'h8000_000C, 1'b1, 32'h0000_0044, 2'b00, 0);
    chk("hit.hit_cnt", hit_cnt, perf(1));

    fetch("conflict", 32'h8000_0104, 1'b0, 32'h9000_0104, 2'b00, 0);
    fetch("conflict_back", 32'h8000_0004, 1'b0, 32'h0000_0022, 2'b00, 0);

    err_addr = 32'h8000_0028;
    fetch("err", 32'h8000_0024, 1'b0, 32'h9000_0024, 2'b10, 0);
    err_addr = 32'hFFFF_FFFF;
    fetch("err_retry", 32'h8000_0024, 1'b0, 32'h9000_0024, 2'b00, 0);

    fork
      fetch("fl_refill", 32'h8000_0044, 1'b0, 32'h9000_0044, 2'b00, 0);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!m_rready && n < 100) begin
          @(negedge clk);
          n++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    fetch("fl_refill_after", 32'h8000_0044, 1'b0, 32'h9000_0044, 2'b00, 0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fetch("fl_idle_after", 32'h8000_0044, 1'b0, 32'h9000_0044, 2'b00, 0);

    fetch("backpressure", 32'h8000_0044, 1'b1, 32'h9000_0044, 2'b00, 5);
    chk("pre_rst.hit_cnt", hit_cnt, perf(exp_hits));
    chk("pre_rst.miss_cnt", miss_cnt, perf(exp_miss));

    // Reset while the refill address phase is on the bus.
    @(negedge clk);
    s_araddr  = 32'h8000_0208;
    s_arvalid = 1'b1;
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
    begin
      int n;
      n = 0;
      while (!m_arvalid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("midrst.reached_ar", 32'(m_arvalid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.arvalid", 32'(m_arvalid), 32'd0);
    chk("midrst.araddr", m_araddr, 32'd0);
    chk("midrst.rready", 32'(m_rready), 32'd0);
    chk("midrst.rvalid", 32'(s_rvalid), 32'd0);
    chk("midrst.arready", 32'(s_arready), 32'd0);
    chk("midrst.hit_cnt", hit_cnt, 32'd0);
    chk("midrst.miss_cnt", miss_cnt, 32'd0);
    rst = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
    fetch("after_rst", 32'h8000_0004, 1'b0, 32'h0000_0022, 2'b00, 0);
    chk("after_rst.miss_cnt", miss_cnt, perf(exp_miss));
    chk("after_rst.hit_cnt", hit_cnt, perf(exp_hits));
    chk("ar_r_overlap", 32'(overlap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
